// File: rtl/flat_shader.sv
// Per-triangle flat shader: face normal, cos^2 Lambert term via a 9-step
// restoring divider, and an 8-bit shade with ambient floor plus front-facing flag.
module flat_shader #(
   parameter int COORD_W = 9,
   parameter int LIGHT_W = 8,
   parameter int AMBIENT = 32
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [COORD_W-1:0]        v1 [3],
   input  logic [COORD_W-1:0]        v2 [3],
   input  logic [COORD_W-1:0]        v3 [3],
   input  logic signed [LIGHT_W-1:0] light [3],
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [7:0]                color_out,
   output logic                      front_out
);

   localparam int EW  = COORD_W + 1;
   localparam int NW  = 2 * COORD_W + 3;
   localparam int DW  = NW + LIGHT_W + 2;
   localparam int D2W = 2 * DW;
   localparam int DDW = D2W + 8;
   localparam int NNW = 2 * NW;
   localparam int LLW = 2 * LIGHT_W + 1;
   localparam int QW  = NNW + LLW;
   localparam int DVW = QW + 8;

   localparam logic [7:0]  AMB  = AMBIENT[7:0];
   localparam logic [15:0] SPAN = 16'(255 - AMBIENT);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_EDGE  = 3'd1,
      ST_CROSS = 3'd2,
      ST_DOT   = 3'd3,
      ST_SQ    = 3'd4,
      ST_DIV   = 3'd5,
      ST_SHADE = 3'd6,
      ST_OUT   = 3'd7
   } state_t;

   function automatic logic signed [NW-1:0] ext_en(input logic signed [EW-1:0] a);
      return {{(NW-EW){a[EW-1]}}, a};
   endfunction

   function automatic logic signed [DW-1:0] ext_nd(input logic signed [NW-1:0] a);
      return {{(DW-NW){a[NW-1]}}, a};
   endfunction

   function automatic logic signed [DW-1:0] ext_ld(input logic signed [LIGHT_W-1:0] a);
      return {{(DW-LIGHT_W){a[LIGHT_W-1]}}, a};
   endfunction

   function automatic logic signed [D2W-1:0] ext_dd(input logic signed [DW-1:0] a);
      return {{(D2W-DW){a[DW-1]}}, a};
   endfunction

   function automatic logic signed [NNW-1:0] ext_nn(input logic signed [NW-1:0] a);
      return {{(NNW-NW){a[NW-1]}}, a};
   endfunction

   function automatic logic signed [LLW-1:0] ext_ll(input logic signed [LIGHT_W-1:0] a);
      return {{(LLW-LIGHT_W){a[LIGHT_W-1]}}, a};
   endfunction

   state_t                    state_r, state_nx_s;
   logic [COORD_W-1:0]        v1_r [3];
   logic [COORD_W-1:0]        v2_r [3];
   logic [COORD_W-1:0]        v3_r [3];
   logic signed [LIGHT_W-1:0] light_r [3];
   logic signed [EW-1:0]      e1_r [3];
   logic signed [EW-1:0]      e2_r [3];
   logic signed [NW-1:0]      n_r [3];
   logic signed [DW-1:0]      d_r;
   logic [NNW-1:0]            nn_r;
   logic [LLW-1:0]            ll_r;
   logic [DDW-1:0]            rem_r;
   logic [DVW-1:0]            div_r;
   logic [8:0]                q_r;
   logic [3:0]                cnt_r;
   logic                      lit_r;

   logic signed [NW-1:0]      cross_s [3];
   logic signed [DW-1:0]      dot_s;
   logic [NNW-1:0]            nn_s;
   logic [LLW-1:0]            ll_s;
   logic signed [D2W-1:0]     d2_s;
   logic [QW-1:0]             q_s;
   logic [DDW-1:0]            div_ext_s;
   logic                      ge_s;
   logic                      lit_s;
   logic [7:0]                qc_s;
   logic [15:0]               prod_s;
   logic [7:0]                shade_s;

   // Arithmetic for every pipeline step, decoded from the registered operands.
   always_comb begin
      cross_s[0] = ext_en(e1_r[1]) * ext_en(e2_r[2]) - ext_en(e1_r[2]) * ext_en(e2_r[1]);
      cross_s[1] = ext_en(e1_r[2]) * ext_en(e2_r[0]) - ext_en(e1_r[0]) * ext_en(e2_r[2]);
      cross_s[2] = ext_en(e1_r[0]) * ext_en(e2_r[1]) - ext_en(e1_r[1]) * ext_en(e2_r[0]);
      dot_s = ext_nd(n_r[0]) * ext_ld(light_r[0])
            + ext_nd(n_r[1]) * ext_ld(light_r[1])
            + ext_nd(n_r[2]) * ext_ld(light_r[2]);
      nn_s = $unsigned(ext_nn(n_r[0]) * ext_nn(n_r[0]))
           + $unsigned(ext_nn(n_r[1]) * ext_nn(n_r[1]))
           + $unsigned(ext_nn(n_r[2]) * ext_nn(n_r[2]));
      ll_s = $unsigned(ext_ll(light_r[0]) * ext_ll(light_r[0]))
           + $unsigned(ext_ll(light_r[1]) * ext_ll(light_r[1]))
           + $unsigned(ext_ll(light_r[2]) * ext_ll(light_r[2]));
      d2_s = ext_dd(d_r) * ext_dd(d_r);
      q_s = {{(QW-NNW){1'b0}}, nn_r} * {{(QW-LLW){1'b0}}, ll_r};
      div_ext_s = {{(DDW-DVW){1'b0}}, div_r};
      ge_s = (rem_r >= div_ext_s);
      lit_s = !d_r[DW-1] && (d_r != '0) && (nn_r != '0) && (ll_r != '0);
      qc_s = q_r[8] ? 8'd255 : q_r[7:0];
      prod_s = SPAN * {8'h00, qc_s};
      shade_s = AMB + prod_s[15:8];
   end

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode; the ambient path skips the divider from SQ.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE:  if (s_valid) state_nx_s = ST_EDGE; else state_nx_s = ST_IDLE;
         ST_EDGE:  state_nx_s = ST_CROSS;
         ST_CROSS: state_nx_s = ST_DOT;
         ST_DOT:   state_nx_s = ST_SQ;
         ST_SQ:    if (lit_s) state_nx_s = ST_DIV; else state_nx_s = ST_SHADE;
         ST_DIV:   if (cnt_r == 4'd8) state_nx_s = ST_SHADE; else state_nx_s = ST_DIV;
         ST_SHADE: state_nx_s = ST_OUT;
         ST_OUT:   if (m_ready) state_nx_s = ST_IDLE; else state_nx_s = ST_OUT;
         default:  state_nx_s = ST_IDLE;
      endcase
   end

   // Datapath and output registers, each stage loading only in its own state.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < 3; i++) begin
            v1_r[i]    <= '0;
            v2_r[i]    <= '0;
            v3_r[i]    <= '0;
            light_r[i] <= '0;
            e1_r[i]    <= '0;
            e2_r[i]    <= '0;
            n_r[i]     <= '0;
         end
         d_r       <= '0;
         nn_r      <= '0;
         ll_r      <= '0;
         rem_r     <= '0;
         div_r     <= '0;
         q_r       <= 9'd0;
         cnt_r     <= 4'd0;
         lit_r     <= 1'b0;
         s_ready   <= 1'b1;
         m_valid   <= 1'b0;
         color_out <= 8'd0;
         front_out <= 1'b0;
      end else begin
         s_ready <= (state_nx_s == ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (s_valid) begin
                  for (int i = 0; i < 3; i++) begin
                     v1_r[i]    <= v1[i];
                     v2_r[i]    <= v2[i];
                     v3_r[i]    <= v3[i];
                     light_r[i] <= light[i];
                  end
               end
            end
            ST_EDGE: begin
               for (int i = 0; i < 3; i++) begin
                  e1_r[i] <= $signed({1'b0, v2_r[i]} - {1'b0, v1_r[i]});
                  e2_r[i] <= $signed({1'b0, v3_r[i]} - {1'b0, v1_r[i]});
               end
            end
            ST_CROSS: begin
               for (int i = 0; i < 3; i++) begin
                  n_r[i] <= cross_s[i];
               end
            end
            ST_DOT: begin
               d_r  <= dot_s;
               nn_r <= nn_s;
               ll_r <= ll_s;
            end
            ST_SQ: begin
               rem_r <= {$unsigned(d2_s), 8'h00};
               div_r <= {q_s, 8'h00};
               q_r   <= 9'd0;
               cnt_r <= 4'd0;
               lit_r <= lit_s;
            end
            ST_DIV: begin
               // Quotient never exceeds 256, so nine trial subtractions of Q<<k suffice.
               if (ge_s) begin
                  rem_r <= rem_r - div_ext_s;
               end
               q_r   <= {q_r[7:0], ge_s};
               div_r <= {1'b0, div_r[DVW-1:1]};
               cnt_r <= cnt_r + 4'd1;
            end
            ST_SHADE: begin
               color_out <= lit_r ? shade_s : AMB;
               front_out <= lit_r;
               m_valid   <= 1'b1;
            end
            ST_OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
               end
            end
            default: begin
               m_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flat_shader.sv
// Directed bench for flat_shader: lit, angled, back-face, degenerate, max-coordinate,
// backpressure and mid-divide reset cases against hand-computed shades and latencies.
module tb_flat_shader;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic              s_valid;
   logic              s_ready;
   logic [8:0]        v1 [3];
   logic [8:0]        v2 [3];
   logic [8:0]        v3 [3];
   logic signed [7:0] light [3];
   logic              m_valid;
   logic              m_ready;
   logic [7:0]        color_out;
   logic              front_out;

   int checks   = 0;
   int failures = 0;

   always #5 aclk = ~aclk;

   flat_shader #(.COORD_W(9), .LIGHT_W(8), .AMBIENT(32)) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .v1        (v1),
      .v2        (v2),
      .v3        (v3),
      .light     (light),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .color_out (color_out),
      .front_out (front_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_tri(input int ax, input int ay, input int az,
                          input int bx, input int by, input int bz,
                          input int cx, input int cy, input int cz,
                          input int lx, input int ly, input int lz);
      v1[0] = 9'(ax); v1[1] = 9'(ay); v1[2] = 9'(az);
      v2[0] = 9'(bx); v2[1] = 9'(by); v2[2] = 9'(bz);
      v3[0] = 9'(cx); v3[1] = 9'(cy); v3[2] = 9'(cz);
      light[0] = 8'(lx); light[1] = 8'(ly); light[2] = 8'(lz);
   endtask

   task automatic accept(input string tag, input bit hold);
      int n = 0;
      s_valid = 1'b1;
      while (!s_ready && n < 50) begin
         @(posedge aclk); #1;
         n++;
      end
      if (!s_ready) check_eq({tag, "_accept_timeout"}, 32'(s_ready), 32'd1);
      @(posedge aclk); #1;
      if (!hold) s_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!m_valid && lat < 40) begin
         @(posedge aclk); #1;
         lat++;
      end
   endtask

   task automatic run_tri(input string tag, input int exp_col, input int exp_front, input int exp_lat);
      int lat;
      accept(tag, 1'b0);
      wait_valid(lat);
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, "_mvalid"}, 32'(m_valid), 32'd1);
      check_eq({tag, "_color"}, 32'(color_out), 32'(exp_col));
      check_eq({tag, "_front"}, 32'(front_out), 32'(exp_front));
      check_eq({tag, "_sready_busy"}, 32'(s_ready), 32'd0);
      @(posedge aclk); #1;
      check_eq({tag, "_mvalid_done"}, 32'(m_valid), 32'd0);
      check_eq({tag, "_sready_done"}, 32'(s_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int lat;
      int pulses;
      aresetn = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;
      set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      check_eq("rst_sready", 32'(s_ready), 32'd1);
      check_eq("rst_mvalid", 32'(m_valid), 32'd0);
      check_eq("rst_color", 32'(color_out), 32'd0);
      check_eq("rst_front", 32'(front_out), 32'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1;

      set_tri(0, 0, 0, 10, 0, 0, 0, 10, 0, 0, 0, 64);
      run_tri("full", 254, 1, 14);
      set_tri(0, 0, 0, 10, 0, 0, 0, 10, 0, 0, 64, 64);
      run_tri("angled", 143, 1, 14);
      set_tri(0, 0, 0, 10, 0, 0, 0, 10, 0, 0, 0, -64);
      run_tri("back", 32, 0, 5);
      set_tri(0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 64);
      run_tri("degen", 32, 0, 5);
      set_tri(511, 0, 0, 0, 511, 0, 0, 0, 511, 127, 127, 127);
      run_tri("maxc", 254, 1, 14);

      // Backpressure: s_valid stays high with a back-face light that must be ignored.
      set_tri(0, 0, 0, 10, 0, 0, 0, 10, 0, 0, 0, 64);
      m_ready = 1'b0;
      accept("bp", 1'b1);
      light[2] = -8'sd64;
      wait_valid(lat);
      check_eq("bp_lat", 32'(lat), 32'd14);
      for (int i = 0; i < 10; i++) begin
         @(posedge aclk); #1;
         check_eq("bp_hold_mvalid", 32'(m_valid), 32'd1);
         check_eq("bp_hold_color", 32'(color_out), 32'd254);
         check_eq("bp_hold_sready", 32'(s_ready), 32'd0);
      end
      m_ready = 1'b1;
      @(posedge aclk); #1;
      check_eq("bp_xfer_mvalid", 32'(m_valid), 32'd0);
      check_eq("bp_xfer_sready", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
      @(posedge aclk); #1;
      check_eq("bp_no_recapture", 32'(s_ready), 32'd1);

      // Reset during the divider drops the triangle.
      set_tri(0, 0, 0, 10, 0, 0, 0, 10, 0, 0, 0, 64);
      accept("rstdiv", 1'b0);
      repeat (7) @(posedge aclk);
      #1;
      aresetn = 1'b0;
      #1;
      check_eq("rstdiv_mvalid", 32'(m_valid), 32'd0);
      check_eq("rstdiv_sready", 32'(s_ready), 32'd1);
      check_eq("rstdiv_color", 32'(color_out), 32'd0);
      check_eq("rstdiv_front", 32'(front_out), 32'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge aclk); #1;
         if (m_valid) pulses++;
      end
      check_eq("rstdiv_no_pulse", 32'(pulses), 32'd0);
      set_tri(0, 0, 0, 10, 0, 0, 0, 10, 0, 0, 64, 64);
      run_tri("after_rst", 143, 1, 14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flat_shader.md
# flat_shader

Parametrised per-triangle flat-shading unit that succeeds the original pixel shader. It takes three screen/world-space vertices and a per-triangle light direction over a valid/ready handshake. It computes the face normal and a cos²θ Lambert term using an iterative divider, then emits one 8-bit shade with ambient floor and a front-facing flag. It sits between the triangle setup/transform stage and the rasteriser colour input.

## Interface
- COORD_W, 9: unsigned vertex coordinate width.
- LIGHT_W, 8: signed light-vector component width.
- AMBIENT, 32: 8-bit shade floor for back-facing, degenerate or unlit triangles.
- aclk  in  1  clock; all state updates on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_valid  in  1  triangle/light input valid.
- s_ready  out  1  block can accept; high only in IDLE.
- v1, v2, v3  in  [COORD_W-1:0] ×3 each  vertex coordinates; index 0=x, 1=y, 2=z; unsigned.
- light  in  signed [LIGHT_W-1:0] ×3  direction from surface toward light; need not be unit length.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- color_out  out  [7:0]  shade.
- front_out  out  1  1 when n·L > 0 and the triangle is non-degenerate.

## Operation
- Inputs are captured only on an s_valid && s_ready edge. Vertices are zero-extended to signed COORD_W+1 bits.
- Edges: e1 = v2−v1, e2 = v3−v1, each COORD_W+1 bits signed.
- Normal: n = e1 × e2, giving NW = 2·COORD_W+3 signed bits per component. Winding is fixed; front face when n·L > 0.
- Dot product: d = n·L, sign-extended to NW+LW+2 bits, with no truncation.
- Magnitudes: |n|² and |L|² computed unsigned at full width.
- SQ stage: dividend D = d²·256; divisor Q = |n|²·|L|².
- Ambient path: if d ≤ 0, |n|² = 0 or |L|² = 0, skip DIV. Output color = AMBIENT, front = 0.
- DIV: restoring division, exactly 9 iterations, producing q = floor(D/Q) in 0..256. q = 256 is clamped to 255.
- Shade: color = AMBIENT + (((255−AMBIENT)·q) >> 8), computed unsigned with no overflow.
- FSM states: IDLE → EDGE → CROSS → DOT → SQ → {DIV ×9 → SHADE | SHADE} → OUT.
- SHADE registers color_out/front_out and sets m_valid; the state moves to OUT.
- OUT holds m_valid and the data stable until m_ready. On transfer, m_valid falls and the state returns to IDLE.
- Input values are ignored in every state except IDLE. Input changes mid-operation have no effect.

## Timing
- Reset (aresetn low, async): state=IDLE, s_ready=1, m_valid=0, color_out=0, front_out=0, datapath regs 0.
- Deassertion is synchronised by the caller; the block is usable on the first edge after release.
- Accept on edge k. m_valid is high after edge k+14 on the lit path and after edge k+5 on the ambient path.
- Fixed latency: no data-dependent variation beyond these two values.
- s_ready is low from edge k until the edge after the output transfer. Minimum initiation interval is 16 cycles on the lit path and 7 on the ambient path, with m_ready held high.
- If m_ready is high in the same cycle m_valid rises, the transfer completes on the next edge.
- Reset asserted mid-operation (any state, including DIV or OUT) aborts immediately. The in-flight triangle is dropped with no output.
- s_valid asserted while s_ready is low is ignored and does not queue.

## Test plan
- Full lighting, AMBIENT=32: v1=(0,0,0), v2=(10,0,0), v3=(0,10,0), light=(0,0,64), m_ready=1.
  - Required: n=(0,0,100), q clamped 255, color_out=254, front_out=1.
  - m_valid rises 14 edges after accept.
- Angled light: same triangle, light=(0,64,64).
  - Required: q=128, color_out=143, front_out=1.
- Back face: same triangle, light=(0,0,−64).
  - Required: color_out=32, front_out=0, m_valid after 5 edges.
  - Degenerate case: v1=(0,0,0), v2=(1,1,1), v3=(2,2,2) with any light gives color_out=32, front_out=0.
- Backpressure: lit triangle, then hold m_ready=0 for 10 cycles while s_valid=1.
  - Required: m_valid and color_out stay stable, s_ready stays 0, no second capture.
  - After m_ready=1: one transfer, s_ready=1 on the next cycle.
- Reset mid-DIV: assert aresetn=0 for 1 cycle at accept+8.
  - Required: outputs immediately reset to the reset values, s_ready=1, no m_valid pulse.
  - A subsequent triangle processes normally.
- Max coordinates, COORD_W=9: v1=(511,0,0), v2=(0,511,0), v3=(0,0,511), light=(127,127,127).
  - Required: n=(261121,261121,261121) with no overflow, q=255 clamp, color_out=254, front_out=1.
